// File: rtl/baud_frac_gen_if.sv
// Configuration bus of the fractional baud generator.
//
// Handshake: there is no ready signal. A write is a single-cycle cfg_we_i
// strobe that carries baud_freq_i/baud_limit_i. The generator answers one
// cycle later, either with cfg_pend_o=1 (shadow loaded) or with a one-cycle
// cfg_err_o pulse (write rejected, nothing changed).
interface baud_frac_gen_if #(
  parameter int CNT_W  = 16,
  parameter int FREQ_W = 12
);
  logic              cfg_we_i;
  logic [FREQ_W-1:0] baud_freq_i;
  logic [CNT_W-1:0]  baud_limit_i;
  logic              cfg_pend_o;
  logic              cfg_err_o;

  modport master (
    output cfg_we_i, baud_freq_i, baud_limit_i,
    input  cfg_pend_o, cfg_err_o
  );

  modport slave (
    input  cfg_we_i, baud_freq_i, baud_limit_i,
    output cfg_pend_o, cfg_err_o
  );
endinterface

// File: rtl/baud_frac_gen.sv
// Fractional baud-rate generator with oversample, mid-bit and bit ticks.
// An accumulator adds freq_act each cycle and, once it reaches lim_act,
// subtracts lim_act and emits an oversample tick. A phase counter divides
// the oversample ticks down to bit and mid-bit ticks. New settings land in a
// shadow pair and are copied to the active pair only at a bit boundary,
// while disabled, or on a phase restart, so a running bit never changes rate.
// Parameter constraints: FREQ_W <= CNT_W, OVS even in 4..256.
module baud_frac_gen #(
  parameter int CNT_W     = 16,
  parameter int FREQ_W    = 12,
  parameter int OVS       = 16,
  parameter int DEF_FREQ  = 576,
  parameter int DEF_LIMIT = 15049,
  localparam int SUB_W    = $clog2(OVS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  baud_frac_gen_if.slave   cfg,
  output logic             ce_ovs_o,
  output logic             ce_bit_o,
  output logic             ce_mid_o,
  output logic [CNT_W-1:0] dbg_cnt_o,
  output logic [SUB_W-1:0] dbg_sub_o
);

  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(OVS - 1);
  localparam logic [SUB_W-1:0]  SUB_MID  = SUB_W'(OVS / 2 - 1);
  localparam logic [FREQ_W-1:0] RST_FREQ = FREQ_W'(DEF_FREQ);
  localparam logic [CNT_W-1:0]  RST_LIM  = CNT_W'(DEF_LIMIT);

  logic [CNT_W-1:0]  r_cnt;
  logic [SUB_W-1:0]  r_sub;
  logic [FREQ_W-1:0] r_freq_act;
  logic [CNT_W-1:0]  r_lim_act;
  logic [FREQ_W-1:0] r_freq_sh;
  logic [CNT_W-1:0]  r_lim_sh;
  logic              r_pend;
  logic              r_err;
  logic              r_ovs;
  logic              r_bit;
  logic              r_mid;

  logic              w_tk;
  logic              w_last;
  logic              w_ap;
  logic              w_wr_ok;
  logic              w_wr_bad;
  logic              w_freq_le_lim;
  logic [CNT_W-1:0]  w_freq_act_ext;
  logic [CNT_W-1:0]  w_freq_in_ext;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [SUB_W-1:0]  w_sub_nxt;

  assign w_freq_act_ext = CNT_W'(r_freq_act);
  assign w_freq_in_ext  = CNT_W'(cfg.baud_freq_i);

  // Tick when enabled, not restarting, and the accumulator reached the limit.
  assign w_tk   = en_i & ~sync_i & (r_cnt >= r_lim_act);
  assign w_last = (r_sub == SUB_LAST);

  // One bit wider than the accumulator so the add can never wrap silently.
  assign w_sum  = {1'b0, r_cnt} + {1'b0, w_freq_act_ext};

  assign w_freq_le_lim = (w_freq_in_ext <= cfg.baud_limit_i);
  assign w_wr_ok       = cfg.cfg_we_i & w_freq_le_lim;
  assign w_wr_bad      = cfg.cfg_we_i & ~w_freq_le_lim;

  // Apply shadow settings only where a rate change cannot split a bit.
  assign w_ap = r_pend & (~en_i | sync_i | (w_tk & w_last));

  // Next accumulator and phase; sync beats enable and tick.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sub_nxt = r_sub;
    if (sync_i) begin
      w_cnt_nxt = '0;
      w_sub_nxt = '0;
    end else if (en_i) begin
      if (w_tk) begin
        w_cnt_nxt = r_cnt - r_lim_act;
        w_sub_nxt = w_last ? '0 : r_sub + SUB_W'(1);
      end else if (w_sum[CNT_W]) begin
        // Only reachable with extreme settings; clamp so the next cycle ticks.
        w_cnt_nxt = '1;
      end else begin
        w_cnt_nxt = w_sum[CNT_W-1:0];
      end
    end
  end

  // Accumulator and phase counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sub <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sub <= w_sub_nxt;
    end
  end

  // Registered tick outputs, one cycle after the tick condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovs <= 1'b0;
      r_bit <= 1'b0;
      r_mid <= 1'b0;
    end else begin
      r_ovs <= w_tk;
      r_bit <= w_tk & w_last;
      r_mid <= w_tk & (r_sub == SUB_MID);
    end
  end

  // Shadow/active configuration; the accumulator above still sees the old
  // active pair on the apply cycle, and a same-cycle write refills the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_freq_act <= RST_FREQ;
      r_lim_act  <= RST_LIM;
      r_freq_sh  <= RST_FREQ;
      r_lim_sh   <= RST_LIM;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_ap) begin
        r_freq_act <= r_freq_sh;
        r_lim_act  <= r_lim_sh;
      end
      if (w_wr_ok) begin
        r_freq_sh <= cfg.baud_freq_i;
        r_lim_sh  <= cfg.baud_limit_i;
        r_pend    <= 1'b1;
      end else if (w_ap) begin
        r_pend    <= 1'b0;
      end
      r_err <= w_wr_bad;
    end
  end

  assign ce_ovs_o       = r_ovs;
  assign ce_bit_o       = r_bit;
  assign ce_mid_o       = r_mid;
  assign cfg.cfg_pend_o = r_pend;
  assign cfg.cfg_err_o  = r_err;
  assign dbg_cnt_o      = r_cnt;
  assign dbg_sub_o      = r_sub;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Bench for baud_frac_gen: cycle scoreboard plus cadence scenarios.
module tb_baud_frac_gen;

  localparam int CNT_W  = 16;
  localparam int FREQ_W = 12;
  localparam int OVS    = 16;
  localparam int SUB_W  = $clog2(OVS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             en_i   = 1'b0;
  logic             sync_i = 1'b0;
  logic             ce_ovs_o, ce_bit_o, ce_mid_o;
  logic [CNT_W-1:0] dbg_cnt_o;
  logic [SUB_W-1:0] dbg_sub_o;

  baud_frac_gen_if #(.CNT_W(CNT_W), .FREQ_W(FREQ_W)) cfg_bus ();

  baud_frac_gen #(
    .CNT_W(CNT_W), .FREQ_W(FREQ_W), .OVS(OVS),
    .DEF_FREQ(576), .DEF_LIMIT(15049)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .sync_i(sync_i), .cfg(cfg_bus),
    .ce_ovs_o(ce_ovs_o), .ce_bit_o(ce_bit_o), .ce_mid_o(ce_mid_o),
    .dbg_cnt_o(dbg_cnt_o), .dbg_sub_o(dbg_sub_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state, kept as plain integers.
  int m_cnt, m_sub, m_fa, m_la, m_fs, m_ls;
  bit m_pend;

  task automatic model_reset();
    m_cnt = 0; m_sub = 0;
    m_fa = 576; m_la = 15049; m_fs = 576; m_ls = 15049;
    m_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit en, input bit sync, input bit we,
                            input int f, input int l, output logic [31:0] e);
    bit tk, last, ap, ok, bad, e_ovs, e_bit, e_mid;
    tk    = en && !sync && (m_cnt >= m_la);
    last  = (m_sub == OVS - 1);
    ap    = m_pend && (!en || sync || (tk && last));
    e_ovs = tk;
    e_bit = tk && last;
    e_mid = tk && (m_sub == OVS / 2 - 1);
    ok    = we && (f <= l);
    bad   = we && !ok;
    if (sync) begin
      m_cnt = 0; m_sub = 0;
    end else if (en) begin
      if (tk) begin
        m_cnt = m_cnt - m_la;
        m_sub = (m_sub + 1) % OVS;
      end else begin
        m_cnt = m_cnt + m_fa;
        if (m_cnt > 65535) m_cnt = 65535;
      end
    end
    if (ap) begin m_fa = m_fs; m_la = m_ls; end
    if (ok) begin m_fs = f; m_ls = l; end
    if (ok) m_pend = 1'b1;
    else if (ap) m_pend = 1'b0;
    e = {11'd0, 16'(m_cnt), e_ovs, e_bit, e_mid, m_pend, bad};
  endtask

  function automatic logic [31:0] dut_vec();
    return {11'd0, dbg_cnt_o, ce_ovs_o, ce_bit_o, ce_mid_o,
            cfg_bus.cfg_pend_o, cfg_bus.cfg_err_o};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs, queues the expectation, compares after the edge.
  task automatic step(input bit en, input bit sync, input bit we, input int f, input int l);
    logic [31:0] e;
    logic [31:0] f_v, l_v;
    f_v = f; l_v = l;
    en_i                 = en;
    sync_i               = sync;
    cfg_bus.cfg_we_i     = we;
    cfg_bus.baud_freq_i  = f_v[FREQ_W-1:0];
    cfg_bus.baud_limit_i = l_v[CNT_W-1:0];
    model_step(en, sync, we, f, l, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("cycle", dut_vec(), e);
  endtask

  task automatic do_reset();
    en_i = 1'b0; sync_i = 1'b0;
    cfg_bus.cfg_we_i = 1'b0; cfg_bus.baud_freq_i = '0; cfg_bus.baud_limit_i = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("reset_state", dut_vec(), 32'd0);
  endtask

  // Write while idle so the new pair applies on the following cycle.
  task automatic cfg_idle(input int f, input int l);
    step(0, 0, 1, f, l);
    step(0, 0, 0, 0, 0);
  endtask

  // ---------------- tests ----------------
  int c_ovs, c_bit, c_mid, last_ovs, last_bit, last_mid, n, mid_at;
  bit seen;

  initial begin
    cfg_bus.cfg_we_i = 1'b0; cfg_bus.baud_freq_i = '0; cfg_bus.baud_limit_i = '0;

    // freq=1, limit=3: ovs every 4, bit every 64, mid 32 before bit
    do_reset();
    cfg_idle(1, 3);
    c_ovs = 0; c_bit = 0; c_mid = 0; last_ovs = -1; last_bit = -1; last_mid = -1000;
    for (int k = 1; k <= 200; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) begin
        if (last_ovs >= 0) check("ovs_period", k - last_ovs, 4);
        last_ovs = k; c_ovs++;
      end
      if (ce_mid_o) begin last_mid = k; c_mid++; end
      if (ce_bit_o) begin
        if (last_bit >= 0) check("bit_period", k - last_bit, 64);
        check("mid_to_bit", k - last_mid, 32);
        last_bit = k; c_bit++;
      end
    end
    check("ovs_count_1_3", c_ovs, 50);
    check("bit_count_1_3", c_bit, 3);
    check("mid_count_1_3", c_mid, 3);

    // defaults over 15625 enabled cycles
    do_reset();
    c_ovs = 0; c_bit = 0;
    for (int k = 0; k < 15625; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) c_ovs++;
      if (ce_bit_o) c_bit++;
    end
    check("def_ovs_count", c_ovs, 576);
    check("def_bit_count", c_bit, 36);

    // 2/5 written mid-bit waits for the bit boundary
    do_reset();
    cfg_idle(1, 3);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_mid_o) seen = 1'b1;
    end
    check("mid_seen", seen, 1);
    step(1, 0, 1, 2, 5);
    check("pend_set", cfg_bus.cfg_pend_o, 1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_bit_o) begin
        seen = 1'b1;
        check("pend_clear_at_bit", cfg_bus.cfg_pend_o, 0);
      end else begin
        check("pend_hold", cfg_bus.cfg_pend_o, 1);
      end
    end
    check("bit_seen", seen, 1);
    c_ovs = 0;
    for (int k = 0; k < 70; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) c_ovs++;
    end
    check("ovs_count_2_5", c_ovs, 20);

    // rejected write 9/4
    do_reset();
    cfg_idle(1, 3);
    repeat (10) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 9, 4);
    check("err_pulse", cfg_bus.cfg_err_o, 1);
    check("err_no_pend", cfg_bus.cfg_pend_o, 0);
    step(1, 0, 0, 0, 0);
    check("err_one_cycle", cfg_bus.cfg_err_o, 0);
    c_ovs = 0;
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) c_ovs++;
    end
    check("ovs_count_after_err", c_ovs, 10);

    // sync with sub=7 and the tick about to fire
    do_reset();
    cfg_idle(1, 3);
    n = 0;
    for (int k = 0; k < 100 && n < 7; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) n++;
    end
    check("sync_pre_ticks", n, 7);
    repeat (3) step(1, 0, 0, 0, 0);
    check("sync_pre_sub", dbg_sub_o, 7);
    step(1, 1, 0, 0, 0);
    check("sync_no_tick", ce_ovs_o, 0);
    n = 0; mid_at = 0;
    for (int k = 0; k < 100 && mid_at == 0; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) n++;
      if (ce_mid_o) mid_at = n;
    end
    check("mid_after_sync", mid_at, 8);

    // asynchronous reset between edges with cnt nonzero and a pending write
    do_reset();
    cfg_idle(1, 3);
    repeat (6) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 2, 5);
    for (int k = 0; k < 4 && m_cnt == 0; k++) step(1, 0, 0, 0, 0);
    check("pre_rst_cnt_nonzero", (dbg_cnt_o != 0), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", dut_vec(), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int k = 1; k <= 100 && n == 0; k++) begin
      step(1, 0, 0, 0, 0);
      if (ce_ovs_o) n = k;
    end
    check("def_first_tick", n, 28);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
